// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: two-requester front end for a shared external multiplier.
// Stage S1 holds the granted operands, which drive mul_a/mul_b. Stage S2
// registers the combinational product mul_p together with the requester id.
// Ties between requesters are broken by a round-robin pointer.
//
// Handshake rules, on both the input and the output side: a transfer happens
// on a rising edge where valid and ready are both 1. The producer keeps
// valid and its payload stable until that edge. out_valid is never retracted
// while out_ready is 0, and out_p/out_id stay stable for that whole time.
module booth_mul_arbiter #(
  parameter int A_W   = 10,
  parameter int B_W   = 10,
  parameter int P_W   = A_W + B_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_0,
  output logic             in_ready_0,
  input  logic [A_W-1:0]   in_a_0,
  input  logic [B_W-1:0]   in_b_0,
  input  logic             in_valid_1,
  output logic             in_ready_1,
  input  logic [A_W-1:0]   in_a_1,
  input  logic [B_W-1:0]   in_b_1,
  output logic [A_W-1:0]   mul_a,
  output logic [B_W-1:0]   mul_b,
  input  logic [P_W-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic             out_id,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  logic             r_s1_v;
  logic             r_s1_id;
  logic [A_W-1:0]   r_s1_a;
  logic [B_W-1:0]   r_s1_b;
  logic             r_out_valid;
  logic [P_W-1:0]   r_out_p;
  logic             r_out_id;
  logic             r_rr;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_s2_adv;
  logic w_s1_adv;
  logic w_both;
  logic w_any;
  logic w_gnt;
  logic w_acc;
  logic w_fire;

  // Pipeline advance conditions, grant selection and the output transfer.
  always_comb begin
    w_s2_adv = !r_out_valid || out_ready;
    w_s1_adv = !r_s1_v || w_s2_adv;
    w_both   = in_valid_0 && in_valid_1;
    w_any    = in_valid_0 || in_valid_1;
    w_gnt    = w_both ? r_rr : in_valid_1;
    w_acc    = rst_n && w_s1_adv && w_any;
    w_fire   = r_out_valid && out_ready;
  end

  // Only the grantee sees ready. Ready is held low while reset is asserted.
  assign in_ready_0 = w_acc && in_valid_0 && !w_gnt;
  assign in_ready_1 = w_acc && in_valid_1 && w_gnt;

  // S1: capture the grantee's operands. When nothing is granted the stage
  // empties, and the old operands are left in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v  <= 1'b0;
      r_s1_id <= 1'b0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= w_any;
      if (w_any) begin
        r_s1_id <= w_gnt;
        r_s1_a  <= w_gnt ? in_a_1 : in_a_0;
        r_s1_b  <= w_gnt ? in_b_1 : in_b_0;
      end
    end
  end

  // S2: register the product of the operands that S1 presents to the tree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_p     <= '0;
      r_out_id    <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_v;
      if (r_s1_v) begin
        r_out_p  <= mul_p;
        r_out_id <= r_s1_id;
      end
    end
  end

  // Round-robin pointer: after a contested grant, point at the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= 1'b0;
    end else if (w_acc && w_both) begin
      r_rr <= !w_gnt;
    end
  end

  // Per-requester completion counters; they saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_fire) begin
      if (!r_out_id && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (r_out_id && (r_cnt1 != {CNT_W{1'b1}}))  r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign mul_a     = r_s1_a;
  assign mul_b     = r_s1_b;
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign out_id    = r_out_id;
  assign done_cnt0 = r_cnt0;
  assign done_cnt1 = r_cnt1;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter. It contains the external multiplier, a
// queue-based reference model, directed scenarios and a randomized phase.
// A second instance built with CNT_W=2 exercises counter saturation.
module tb_booth_mul_arbiter;
  localparam int A_W   = 10;
  localparam int B_W   = 10;
  localparam int P_W   = 20;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid_0, in_valid_1, out_ready;
  logic [A_W-1:0]   in_a_0, in_a_1;
  logic [B_W-1:0]   in_b_0, in_b_1;
  logic             in_ready_0, in_ready_1;
  logic [A_W-1:0]   mul_a;
  logic [B_W-1:0]   mul_b;
  logic [P_W-1:0]   mul_p;
  logic             out_valid, out_id;
  logic [P_W-1:0]   out_p;
  logic [CNT_W-1:0] done_cnt0, done_cnt1;

  logic             s_in_ready_0, s_in_ready_1, s_out_valid, s_out_id;
  logic [A_W-1:0]   s_mul_a;
  logic [B_W-1:0]   s_mul_b;
  logic [P_W-1:0]   s_mul_p, s_out_p;
  logic [1:0]       s_done_cnt0, s_done_cnt1;

  // External multiplier trees feeding each instance.
  assign mul_p   = {{B_W{1'b0}}, mul_a} * {{A_W{1'b0}}, mul_b};
  assign s_mul_p = {{B_W{1'b0}}, s_mul_a} * {{A_W{1'b0}}, s_mul_b};

  booth_mul_arbiter #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_0(in_valid_0), .in_ready_0(in_ready_0), .in_a_0(in_a_0), .in_b_0(in_b_0),
    .in_valid_1(in_valid_1), .in_ready_1(in_ready_1), .in_a_1(in_a_1), .in_b_1(in_b_1),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_id(out_id),
    .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
  );

  booth_mul_arbiter #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid_0(in_valid_0), .in_ready_0(s_in_ready_0), .in_a_0(in_a_0), .in_b_0(in_b_0),
    .in_valid_1(in_valid_1), .in_ready_1(s_in_ready_1), .in_a_1(in_a_1), .in_b_1(in_b_1),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p), .out_id(s_out_id),
    .done_cnt0(s_done_cnt0), .done_cnt1(s_done_cnt1)
  );

  // ---------------- scoreboard / model state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [P_W:0] exp_q[$];    // {id, product} in acceptance order
  bit           newest_in_s1; // last model action was an acceptance
  bit           rr_m;
  int           cnt_m[2];
  int           cnt_s[2];
  logic [19:0]  ops0[$], ops1[$]; // {a, b} waiting at each requester
  bit           hold0, hold1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] rand_op();
    logic [9:0] a, b;
    a = 10'($urandom_range(0, 1023));
    b = 10'($urandom_range(0, 1023));
    if ($urandom_range(0, 7) == 0) a = 10'd1023;
    if ($urandom_range(0, 7) == 0) b = ($urandom_range(0, 1) == 1) ? 10'd0 : 10'd1023;
    return {a, b};
  endfunction

  // ---------------- driver + model step (one clock) ----------------
  task automatic step(input bit ordy, input bit rnd);
    bit v0, v1, exp_ov, fire, can, g, er0, er1;
    logic [19:0] op;
    logic [P_W:0] head;
    int prod;
    v0 = (ops0.size() > 0) && (hold0 || !rnd || ($urandom_range(0, 3) != 0));
    v1 = (ops1.size() > 0) && (hold1 || !rnd || ($urandom_range(0, 3) != 0));
    in_valid_0 = v0;
    in_valid_1 = v1;
    op = v0 ? ops0[0] : rand_op();
    in_a_0 = op[19:10];
    in_b_0 = op[9:0];
    op = v1 ? ops1[0] : rand_op();
    in_a_1 = op[19:10];
    in_b_1 = op[9:0];
    out_ready = ordy;
    #1;
    // A single item is still in S1 if it was accepted on the last edge.
    exp_ov = (exp_q.size() > 1) || (exp_q.size() == 1 && !newest_in_s1);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      head = exp_q[0];
      chk("out_p", {12'd0, out_p}, {12'd0, head[P_W-1:0]});
      chk("out_id", {31'd0, out_id}, {31'd0, head[P_W]});
    end
    chk("done_cnt0", {16'd0, done_cnt0}, cnt_m[0]);
    chk("done_cnt1", {16'd0, done_cnt1}, cnt_m[1]);
    chk("sat_cnt0", {30'd0, s_done_cnt0}, cnt_s[0]);
    chk("sat_cnt1", {30'd0, s_done_cnt1}, cnt_s[1]);
    fire = exp_ov && ordy;
    can  = (exp_q.size() - int'(fire)) < 2;
    g    = (v0 && v1) ? rr_m : v1;
    er0  = can && v0 && !g;
    er1  = can && v1 && g;
    chk("in_ready_0", {31'd0, in_ready_0}, {31'd0, er0});
    chk("in_ready_1", {31'd0, in_ready_1}, {31'd0, er1});
    if (fire) begin
      head = exp_q.pop_front();
      if (cnt_m[head[P_W]] < 65535) cnt_m[head[P_W]]++;
      if (cnt_s[head[P_W]] < 3) cnt_s[head[P_W]]++;
    end
    if (er0 || er1) begin
      op = er1 ? ops1[0] : ops0[0];
      prod = int'(op[19:10]) * int'(op[9:0]);
      exp_q.push_back({er1, prod[P_W-1:0]});
      if (v0 && v1) rr_m = !g;
    end
    newest_in_s1 = er0 || er1;
    if (er0) begin void'(ops0.pop_front()); hold0 = 1'b0; end else hold0 = v0;
    if (er1) begin void'(ops1.pop_front()); hold1 = 1'b0; end else hold1 = v1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && ops0.size() == 0 && ops1.size() == 0) break;
      step(1'b1, 1'b0);
    end
    chk("drained", exp_q.size() + ops0.size() + ops1.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    in_valid_0 = 1'b1; in_valid_1 = 1'b1; out_ready = 1'b1;
    in_a_0 = 10'd5; in_b_0 = 10'd5; in_a_1 = 10'd6; in_b_1 = 10'd6;
    rr_m = 1'b0; newest_in_s1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0; cnt_s[0] = 0; cnt_s[1] = 0;
    repeat (3) @(negedge clk);
    // Reset state, with both requesters asserting valid.
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready_0", {31'd0, in_ready_0}, 0);
    chk("rst_in_ready_1", {31'd0, in_ready_1}, 0);
    chk("rst_mul_a", {22'd0, mul_a}, 0);
    chk("rst_mul_b", {22'd0, mul_b}, 0);
    chk("rst_out_p", {12'd0, out_p}, 0);
    chk("rst_out_id", {31'd0, out_id}, 0);
    chk("rst_cnt0", {16'd0, done_cnt0}, 0);
    rst_n = 1'b1;

    // Single op 12*34 from requester 0.
    ops0.push_back({10'd12, 10'd34});
    repeat (4) step(1'b1, 1'b0);
    chk("single_cnt0", {16'd0, done_cnt0}, 1);

    // Contention: grants alternate 0,1,0,1.
    repeat (4) begin
      ops0.push_back({10'd3, 10'd5});
      ops1.push_back({10'd7, 10'd9});
    end
    drain();

    // Backpressure: three ops from requester 1, out_ready held low for 4 cycles.
    ops1.push_back({10'd11, 10'd13});
    ops1.push_back({10'd17, 10'd19});
    ops1.push_back({10'd23, 10'd29});
    repeat (4) step(1'b0, 1'b0);
    drain();

    // Operand corners.
    ops0.push_back({10'd1023, 10'd1023});
    ops0.push_back({10'd0, 10'd1023});
    ops0.push_back({10'd1023, 10'd1});
    drain();

    // Reset with two ops in flight.
    ops0.push_back({10'd5, 10'd6});
    ops0.push_back({10'd7, 10'd8});
    repeat (2) step(1'b0, 1'b0);
    in_valid_0 = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_in_ready_0", {31'd0, in_ready_0}, 0);
    chk("midrst_cnt0", {16'd0, done_cnt0}, 0);
    chk("midrst_cnt1", {16'd0, done_cnt1}, 0);
    exp_q.delete(); ops0.delete(); ops1.delete();
    rr_m = 1'b0; newest_in_s1 = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0; cnt_s[0] = 0; cnt_s[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(1'b1, 1'b0);
    // First contested grant after reset must go to requester 0.
    ops0.push_back({10'd2, 10'd3});
    ops1.push_back({10'd4, 10'd5});
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      if (ops0.size() < 3) ops0.push_back(rand_op());
      if (ops1.size() < 3) ops1.push_back(rand_op());
      step($urandom_range(0, 3) != 0, 1'b1);
    end
    drain();

    // Requester 0 has completed well over three results by now.
    chk("saturated_cnt0", {30'd0, s_done_cnt0}, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
